// File: rtl/aquila_amo_pkg.sv
// Shared definitions for the Aquila atomic memory operation unit:
// FSM state encoding, RISC-V AMO funct5 codes and small decode helpers.
package aquila_amo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_RESP    = 3'd4
  } amo_state_e;

  localparam logic [4:0] AMO_ADD  = 5'b00000;
  localparam logic [4:0] AMO_SWAP = 5'b00001;
  localparam logic [4:0] AMO_LR   = 5'b00010;
  localparam logic [4:0] AMO_SC   = 5'b00011;
  localparam logic [4:0] AMO_XOR  = 5'b00100;
  localparam logic [4:0] AMO_OR   = 5'b01000;
  localparam logic [4:0] AMO_AND  = 5'b01100;
  localparam logic [4:0] AMO_MIN  = 5'b10000;
  localparam logic [4:0] AMO_MAX  = 5'b10100;
  localparam logic [4:0] AMO_MINU = 5'b11000;
  localparam logic [4:0] AMO_MAXU = 5'b11100;

  // True for a load-reserved request.
  function automatic logic is_lr(input logic is_amo, input logic [4:0] amo_type);
    return is_amo && (amo_type == AMO_LR);
  endfunction

  // True for a store-conditional request.
  function automatic logic is_sc(input logic is_amo, input logic [4:0] amo_type);
    return is_amo && (amo_type == AMO_SC);
  endfunction

endpackage

// File: rtl/aquila_amo_alu.sv
// Combinational AMO arithmetic: combines the old memory word with rs2.
// Signed/unsigned MIN/MAX are only built when AQUILA_AMO_MINMAX_EN is defined;
// otherwise those codes fall through to SWAP like any other unlisted code.
module aquila_amo_alu
  import aquila_amo_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      amo_type,
  output logic [XLEN-1:0] result
);

  // Select the AMO result for the requested funct5 code
  always_comb begin
    result = rs2_val;
    case (amo_type)
      AMO_SWAP: result = rs2_val;
      AMO_ADD:  result = old_val + rs2_val;
      AMO_XOR:  result = old_val ^ rs2_val;
      AMO_AND:  result = old_val & rs2_val;
      AMO_OR:   result = old_val | rs2_val;
`ifdef AQUILA_AMO_MINMAX_EN
      AMO_MIN:  result = ($signed(old_val) < $signed(rs2_val)) ? old_val : rs2_val;
      AMO_MAX:  result = ($signed(old_val) > $signed(rs2_val)) ? old_val : rs2_val;
      AMO_MINU: result = (old_val < rs2_val) ? old_val : rs2_val;
      AMO_MAXU: result = (old_val > rs2_val) ? old_val : rs2_val;
`endif
      default:  result = rs2_val;
    endcase
  end

endmodule

// File: rtl/aquila_amo_unit.sv
// Aquila AMO unit: sits between the core and memory, turning plain loads and
// stores into single accesses and AMOs into read-modify-write sequences,
// with an LR/SC reservation on one word address.
// Optional MIN/MAX family enabled by the AQUILA_AMO_MINMAX_EN macro.
module aquila_amo_unit
  import aquila_amo_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req_i,
  input  logic [XLEN-1:0]   core_addr_i,
  input  logic [XLEN-1:0]   core_data_i,
  input  logic              core_rw_i,
  input  logic [XLEN/8-1:0] core_byte_enable_i,
  input  logic              core_is_amo_i,
  input  logic [4:0]        core_amo_type_i,
  output logic [XLEN-1:0]   core_data_o,
  output logic              core_ready_o,
  output logic              mem_req_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_data_o,
  output logic              mem_rw_o,
  output logic [XLEN/8-1:0] mem_byte_enable_o,
  input  logic [XLEN-1:0]   mem_data_i,
  input  logic              mem_ready_i
);

  localparam int BEW = XLEN / 8;

  amo_state_e        state_r;
  logic [XLEN-1:0]   addr_r;
  logic [XLEN-1:0]   data_r;
  logic [XLEN-1:0]   old_r;
  logic              rw_r;
  logic [BEW-1:0]    be_r;
  logic              is_amo_r;
  logic [4:0]        type_r;
  logic              resv_valid_r;
  logic [XLEN-3:0]   resv_word_r;

  logic [XLEN-1:0]   req_addr_s;
  logic [BEW-1:0]    req_be_s;
  logic              core_hit_s;
  logic              lat_hit_s;
  logic [XLEN-1:0]   alu_result_s;

  // Effective address/byte enables of the incoming request and reservation matches
  always_comb begin
    if (core_is_amo_i) begin
      req_addr_s = {core_addr_i[XLEN-1:2], 2'b00};
      req_be_s   = {BEW{1'b1}};
    end else begin
      req_addr_s = core_addr_i;
      req_be_s   = core_byte_enable_i;
    end
    core_hit_s = resv_valid_r && (resv_word_r == core_addr_i[XLEN-1:2]);
    lat_hit_s  = resv_valid_r && (resv_word_r == addr_r[XLEN-1:2]);
  end

  // The old value comes straight from the memory bus so the write can issue
  // on the cycle right after read data returns.
  aquila_amo_alu #(.XLEN(XLEN)) u_alu (
    .old_val  (mem_data_i),
    .rs2_val  (data_r),
    .amo_type (type_r),
    .result   (alu_result_s)
  );

  // Request FSM with registered core and memory outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r           <= ST_IDLE;
      addr_r            <= {XLEN{1'b0}};
      data_r            <= {XLEN{1'b0}};
      old_r             <= {XLEN{1'b0}};
      rw_r              <= 1'b0;
      be_r              <= {BEW{1'b0}};
      is_amo_r          <= 1'b0;
      type_r            <= 5'd0;
      resv_valid_r      <= 1'b0;
      resv_word_r       <= {(XLEN-2){1'b0}};
      core_data_o       <= {XLEN{1'b0}};
      core_ready_o      <= 1'b0;
      mem_req_o         <= 1'b0;
      mem_addr_o        <= {XLEN{1'b0}};
      mem_data_o        <= {XLEN{1'b0}};
      mem_rw_o          <= 1'b0;
      mem_byte_enable_o <= {BEW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          core_ready_o <= 1'b0;
          if (core_req_i) begin
            addr_r   <= req_addr_s;
            data_r   <= core_data_i;
            rw_r     <= core_rw_i;
            be_r     <= req_be_s;
            is_amo_r <= core_is_amo_i;
            type_r   <= core_amo_type_i;
            if (is_sc(core_is_amo_i, core_amo_type_i)) begin
              // SC consumes the reservation whether or not it succeeds
              resv_valid_r <= 1'b0;
              if (core_hit_s) begin
                mem_req_o         <= 1'b1;
                mem_rw_o          <= 1'b1;
                mem_addr_o        <= req_addr_s;
                mem_byte_enable_o <= req_be_s;
                mem_data_o        <= core_data_i;
                state_r           <= ST_WR_REQ;
              end else begin
                core_ready_o <= 1'b1;
                core_data_o  <= {{(XLEN-1){1'b0}}, 1'b1};
                state_r      <= ST_RESP;
              end
            end else if (!core_is_amo_i && core_rw_i) begin
              if (core_hit_s) begin
                resv_valid_r <= 1'b0;
              end
              mem_req_o         <= 1'b1;
              mem_rw_o          <= 1'b1;
              mem_addr_o        <= req_addr_s;
              mem_byte_enable_o <= req_be_s;
              mem_data_o        <= core_data_i;
              state_r           <= ST_WR_REQ;
            end else begin
              mem_req_o         <= 1'b1;
              mem_rw_o          <= 1'b0;
              mem_addr_o        <= req_addr_s;
              mem_byte_enable_o <= req_be_s;
              state_r           <= ST_RD_REQ;
            end
          end
        end
        ST_RD_REQ: begin
          mem_req_o <= 1'b0;
          state_r   <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (mem_ready_i) begin
            old_r <= mem_data_i;
            if ((!is_amo_r && !rw_r) || is_lr(is_amo_r, type_r)) begin
              if (is_lr(is_amo_r, type_r)) begin
                resv_valid_r <= 1'b1;
                resv_word_r  <= addr_r[XLEN-1:2];
              end
              core_ready_o <= 1'b1;
              core_data_o  <= mem_data_i;
              state_r      <= ST_RESP;
            end else begin
              if (lat_hit_s) begin
                resv_valid_r <= 1'b0;
              end
              mem_req_o         <= 1'b1;
              mem_rw_o          <= 1'b1;
              mem_addr_o        <= addr_r;
              mem_byte_enable_o <= be_r;
              mem_data_o        <= alu_result_s;
              state_r           <= ST_WR_REQ;
            end
          end
        end
        ST_WR_REQ: begin
          mem_req_o    <= 1'b0;
          mem_rw_o     <= 1'b0;
          core_ready_o <= 1'b1;
          if (is_amo_r && !is_sc(is_amo_r, type_r)) begin
            core_data_o <= old_r;
          end else begin
            core_data_o <= {XLEN{1'b0}};
          end
          state_r <= ST_RESP;
        end
        ST_RESP: begin
          core_ready_o <= 1'b0;
          state_r      <= ST_IDLE;
        end
        default: begin
          core_ready_o <= 1'b0;
          mem_req_o    <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aquila_amo_unit.sv
// Directed scoreboard bench for aquila_amo_unit: expected memory accesses and
// core responses are queued as each request is driven and compared as the
// DUT produces them. Build with AQUILA_AMO_MINMAX_EN to cover MIN/MAX.
module tb_aquila_amo_unit;
  import aquila_amo_pkg::*;

  localparam int XLEN = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              core_req_i = 1'b0;
  logic [XLEN-1:0]   core_addr_i = 32'h0;
  logic [XLEN-1:0]   core_data_i = 32'h0;
  logic              core_rw_i = 1'b0;
  logic [XLEN/8-1:0] core_byte_enable_i = 4'h0;
  logic              core_is_amo_i = 1'b0;
  logic [4:0]        core_amo_type_i = 5'd0;
  logic [XLEN-1:0]   core_data_o;
  logic              core_ready_o;
  logic              mem_req_o;
  logic [XLEN-1:0]   mem_addr_o;
  logic [XLEN-1:0]   mem_data_o;
  logic              mem_rw_o;
  logic [XLEN/8-1:0] mem_byte_enable_o;
  logic [XLEN-1:0]   mem_data_i = 32'h0;
  logic              mem_ready_i = 1'b0;

  aquila_amo_unit #(.XLEN(XLEN)) dut (
    .clk                (clk),
    .rst                (rst),
    .core_req_i         (core_req_i),
    .core_addr_i        (core_addr_i),
    .core_data_i        (core_data_i),
    .core_rw_i          (core_rw_i),
    .core_byte_enable_i (core_byte_enable_i),
    .core_is_amo_i      (core_is_amo_i),
    .core_amo_type_i    (core_amo_type_i),
    .core_data_o        (core_data_o),
    .core_ready_o       (core_ready_o),
    .mem_req_o          (mem_req_o),
    .mem_addr_o         (mem_addr_o),
    .mem_data_o         (mem_data_o),
    .mem_rw_o           (mem_rw_o),
    .mem_byte_enable_o  (mem_byte_enable_o),
    .mem_data_i         (mem_data_i),
    .mem_ready_i        (mem_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rw;
    logic [3:0]  be;
  } mem_exp_t;

  mem_exp_t    exp_mem_q[$];
  logic [31:0] exp_rsp_q[$];
  int          total_cnt = 0;
  int          pass_cnt  = 0;
  string       cur_tag   = "reset";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Scoreboard: pop and compare on every memory request and core response
  always @(negedge clk) begin : monitor
    mem_exp_t e;
    if (!rst && mem_req_o) begin
      if (exp_mem_q.size() == 0) begin
        check({cur_tag, "/unexpected_mem_req"}, {31'd0, mem_req_o}, 32'd0);
      end else begin
        e = exp_mem_q.pop_front();
        check({cur_tag, "/mem_rw"}, {31'd0, mem_rw_o}, {31'd0, e.rw});
        check({cur_tag, "/mem_addr"}, mem_addr_o, e.addr);
        check({cur_tag, "/mem_be"}, {28'd0, mem_byte_enable_o}, {28'd0, e.be});
        if (e.rw) check({cur_tag, "/mem_wdata"}, mem_data_o, e.data);
      end
    end
    if (!rst && core_ready_o) begin
      if (exp_rsp_q.size() == 0) begin
        check({cur_tag, "/unexpected_rsp"}, {31'd0, core_ready_o}, 32'd0);
      end else begin
        check({cur_tag, "/rsp_data"}, core_data_o, exp_rsp_q.pop_front());
      end
    end
  end

  // One core transaction: queue expectations, drive, answer reads, time the response.
  // exp_lat counts cycles from the sampling edge of mem_ready_i (or of core_req_i
  // when no read happens) to the cycle in which core_ready_o is high.
  task automatic txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic rw, input logic [3:0] be, input logic amo, input logic [4:0] typ,
                     input logic [31:0] rdata, input int dly, input logic exp_wr,
                     input logic [31:0] exp_wdata, input logic [31:0] exp_rsp, input int exp_lat);
    logic        has_rd;
    logic [31:0] eaddr;
    logic [3:0]  ebe;
    int          rdy_edge;
    bit          done;
    has_rd = amo ? (typ != AMO_SC) : !rw;
    eaddr  = amo ? {addr[31:2], 2'b00} : addr;
    ebe    = amo ? 4'hF : be;
    @(negedge clk);
    cur_tag = tag;
    if (has_rd) exp_mem_q.push_back('{addr: eaddr, data: 32'h0, rw: 1'b0, be: ebe});
    if (exp_wr) exp_mem_q.push_back('{addr: eaddr, data: exp_wdata, rw: 1'b1, be: ebe});
    exp_rsp_q.push_back(exp_rsp);
    core_addr_i        = addr;
    core_data_i        = wdata;
    core_rw_i          = rw;
    core_byte_enable_i = be;
    core_is_amo_i      = amo;
    core_amo_type_i    = typ;
    core_req_i         = 1'b1;
    rdy_edge = 0;
    done     = 1'b0;
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge clk);
      if (core_ready_o) begin
        check({tag, "/latency"}, k, rdy_edge + exp_lat);
        core_req_i = 1'b0;
        done       = 1'b1;
      end
      if (has_rd && k == 2 + dly) begin
        mem_ready_i = 1'b1;
        mem_data_i  = rdata;
        rdy_edge    = k;
      end else begin
        mem_ready_i = 1'b0;
      end
    end
    mem_ready_i = 1'b0;
    core_req_i  = 1'b0;
    if (!done) check({tag, "/timeout"}, 32'd0, 32'd1);
  endtask

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog expired: observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit busy_seen;
    repeat (2) @(negedge clk);
    check("reset/core_ready", {31'd0, core_ready_o}, 32'd0);
    check("reset/core_data", core_data_o, 32'd0);
    check("reset/mem_req", {31'd0, mem_req_o}, 32'd0);
    check("reset/mem_rw", {31'd0, mem_rw_o}, 32'd0);
    check("reset/mem_addr", mem_addr_o, 32'd0);
    check("reset/mem_data", mem_data_o, 32'd0);
    check("reset/mem_be", {28'd0, mem_byte_enable_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    //   tag           addr      wdata         rw    be    amo   type     rdata         dly wr    wdata         rsp           lat
    txn("wr_plain",  32'h100, 32'hDEADBEEF, 1'b1, 4'hF, 1'b0, AMO_ADD, 32'h0,        0, 1'b1, 32'hDEADBEEF, 32'h0,        2);
    txn("rd_plain",  32'h101, 32'h0,        1'b0, 4'h2, 1'b0, AMO_ADD, 32'h12345678, 1, 1'b0, 32'h0,        32'h12345678, 1);
    check("hold/core_data", core_data_o, 32'h12345678);
    txn("amo_add",   32'h200, 32'h3,        1'b1, 4'h1, 1'b1, AMO_ADD, 32'h5,        0, 1'b1, 32'h8,        32'h5,        2);
    txn("amo_wrap",  32'h204, 32'h2,        1'b1, 4'hF, 1'b1, AMO_ADD, 32'hFFFFFFFF, 2, 1'b1, 32'h1,        32'hFFFFFFFF, 2);
    txn("amo_swap",  32'h206, 32'hAB,       1'b1, 4'h3, 1'b1, AMO_SWAP,32'h11,       0, 1'b1, 32'hAB,       32'h11,       2);
    txn("amo_xor",   32'h208, 32'hFF00,     1'b1, 4'hF, 1'b1, AMO_XOR, 32'hF0F0,     0, 1'b1, 32'h0FF0,     32'hF0F0,     2);
    txn("amo_and",   32'h208, 32'hFF00,     1'b1, 4'hF, 1'b1, AMO_AND, 32'hF0F0,     0, 1'b1, 32'hF000,     32'hF0F0,     2);
    txn("amo_or",    32'h208, 32'hFF00,     1'b1, 4'hF, 1'b1, AMO_OR,  32'hF0F0,     0, 1'b1, 32'hFFF0,     32'hF0F0,     2);
    txn("amo_undef", 32'h20C, 32'h77,       1'b1, 4'hF, 1'b1, 5'b00101,32'h1,        0, 1'b1, 32'h77,       32'h1,        2);

    txn("lr1",       32'h300, 32'h0,        1'b0, 4'hF, 1'b1, AMO_LR,  32'h55,       0, 1'b0, 32'h0,        32'h55,       1);
    txn("sc1_ok",    32'h300, 32'hA,        1'b1, 4'hF, 1'b1, AMO_SC,  32'h0,        0, 1'b1, 32'hA,        32'h0,        2);
    txn("sc1_again", 32'h300, 32'hA,        1'b1, 4'hF, 1'b1, AMO_SC,  32'h0,        0, 1'b0, 32'h0,        32'h1,        1);
    repeat (3) @(negedge clk);
    check("hold/sc_fail", core_data_o, 32'h1);

    txn("lr2",       32'h300, 32'h0,        1'b0, 4'hF, 1'b1, AMO_LR,  32'h56,       0, 1'b0, 32'h0,        32'h56,       1);
    txn("wr_302",    32'h302, 32'h99,       1'b1, 4'h4, 1'b0, AMO_ADD, 32'h0,        0, 1'b1, 32'h99,       32'h0,        2);
    txn("sc2_fail",  32'h300, 32'hA,        1'b1, 4'hF, 1'b1, AMO_SC,  32'h0,        0, 1'b0, 32'h0,        32'h1,        1);

    txn("lr3",       32'h300, 32'h0,        1'b0, 4'hF, 1'b1, AMO_LR,  32'h57,       0, 1'b0, 32'h0,        32'h57,       1);
    txn("amo_clr",   32'h300, 32'h1,        1'b1, 4'hF, 1'b1, AMO_ADD, 32'h57,       0, 1'b1, 32'h58,       32'h57,       2);
    txn("sc3_fail",  32'h300, 32'hA,        1'b1, 4'hF, 1'b1, AMO_SC,  32'h0,        0, 1'b0, 32'h0,        32'h1,        1);

    // Reset while a read waits for data; the late data must be ignored
    txn("lr_pre_rst",32'h500, 32'h0,        1'b0, 4'hF, 1'b1, AMO_LR,  32'h66,       0, 1'b0, 32'h0,        32'h66,       1);
    @(negedge clk);
    cur_tag = "rst_mid";
    exp_mem_q.push_back('{addr: 32'h400, data: 32'h0, rw: 1'b0, be: 4'hF});
    core_addr_i        = 32'h400;
    core_rw_i          = 1'b0;
    core_is_amo_i      = 1'b0;
    core_byte_enable_i = 4'hF;
    core_req_i         = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    core_req_i = 1'b0;
    check("rst_mid/core_data", core_data_o, 32'h0);
    check("rst_mid/mem_addr", mem_addr_o, 32'h0);
    busy_seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (core_ready_o || mem_req_o) busy_seen = 1'b1;
      mem_ready_i = (k == 0);
      mem_data_i  = 32'hBAD0BAD0;
    end
    mem_ready_i = 1'b0;
    check("rst_mid/quiet", {31'd0, busy_seen}, 32'd0);
    txn("sc_post_rst",32'h500, 32'hA,       1'b1, 4'hF, 1'b1, AMO_SC,  32'h0,        0, 1'b0, 32'h0,        32'h1,        1);

`ifdef AQUILA_AMO_MINMAX_EN
    txn("amo_min",   32'h600, 32'h1,        1'b1, 4'hF, 1'b1, AMO_MIN, 32'h80000000, 0, 1'b1, 32'h80000000, 32'h80000000, 2);
    txn("amo_max",   32'h600, 32'h1,        1'b1, 4'hF, 1'b1, AMO_MAX, 32'h80000000, 0, 1'b1, 32'h1,        32'h80000000, 2);
    txn("amo_minu",  32'h600, 32'h1,        1'b1, 4'hF, 1'b1, AMO_MINU,32'h80000000, 0, 1'b1, 32'h1,        32'h80000000, 2);
    txn("amo_maxu",  32'h600, 32'h1,        1'b1, 4'hF, 1'b1, AMO_MAXU,32'h80000000, 0, 1'b1, 32'h80000000, 32'h80000000, 2);
`else
    txn("amo_min_sw",32'h600, 32'h1,        1'b1, 4'hF, 1'b1, AMO_MIN, 32'h80000000, 0, 1'b1, 32'h1,        32'h80000000, 2);
    txn("amo_maxu_sw",32'h600,32'h2,        1'b1, 4'hF, 1'b1, AMO_MAXU,32'h80000000, 0, 1'b1, 32'h2,        32'h80000000, 2);
`endif

    repeat (2) @(negedge clk);
    check("sb/mem_left", exp_mem_q.size(), 32'd0);
    check("sb/rsp_left", exp_rsp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
